cubic: RTL and testbench
========================

CUBIC -- requirements
Module: cubic

Interface
REQ-001 The module SHALL have no parameters; operand width is fixed at 8 bits and result width at 3 bits.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset; asynchronous and active-low.
REQ-004 x_bi  input  8  unsigned radicand; sampled only on accepted start.
REQ-005 start_i  input  1  start request; accepted only in IDLE.
REQ-006 busy_o  output  1  high while a computation is in progress.
REQ-007 y_bo  output  3  floor(cbrt(x)); holds the last result until the next completion.
REQ-008 addsub_req  output  1  shared adder/subtractor request.
REQ-009 addsub_ready  input  1  grant; the shared unit serves this block during a cycle with addsub_ready=1.
REQ-010 addsub_mode  output  1  1=add, 0=subtract.
REQ-011 addsub_a, addsub_b  output  8 each  operands.
REQ-012 addsub_res  input  8  combinational result, valid during a grant cycle.

Function
REQ-013 States SHALL be IDLE, CALC and REQ.
- IDLE with start_i=1: latch x_bi into the 8-bit working remainder r, clear y, set shift s=6, go to CALC.
- start_i SHALL be ignored outside IDLE.
REQ-014 CALC SHALL take one cycle and perform:
- y := 2*y;
- b := (3*y*(y+1)+1) << s, computed internally and always fitting in 8 bits;
- go to REQ.
REQ-015 In REQ:
- assert addsub_req=1, addsub_mode=0, addsub_a=r, addsub_b=b;
- hold these outputs stable until a clock edge with addsub_ready=1.
REQ-016 On the edge with addsub_ready=1:
- if r >= b (internal unsigned compare), r := addsub_res and y := y+1;
- then if s==0, load y_bo with the final y and go to IDLE; else s := s-3 and go to CALC.
REQ-017 addsub_res SHALL be sampled only on grant edges; addsub_ready while not in REQ SHALL be ignored.
REQ-018 When addsub_req=0: addsub_a=0, addsub_b=0, addsub_mode=1.
REQ-019 busy_o SHALL be 1 in CALC and REQ, and 0 in IDLE.
REQ-020 With addsub_ready held at 1, busy_o SHALL be high for exactly 6 cycles; each cycle of ready delay adds one cycle.
REQ-021 y_bo SHALL change only on the completing edge; it is valid in the first cycle busy_o is low.
REQ-022 A start_i high on the completing edge SHALL NOT start a new computation; start is evaluated in IDLE on the following cycle.
REQ-023 The system arbiter that drives addsub_ready SHALL be built from ec4_2 and dc2_4:
- ec4_2: 4-to-2 priority encoder, highest-index asserted request wins, all-zero input encodes 0;
- dc2_4: 2-to-4 one-hot decoder;
- cubic occupies request index 1.

Reset
REQ-024 rst_i low SHALL immediately force the following, regardless of clock:
- state IDLE, busy_o=0, y_bo=0, addsub_req=0;
- r=0, y=0, s=0.
REQ-025 Reset mid-computation SHALL abort the computation; no partial result appears on y_bo.
REQ-026 After reset release, the first start_i SHALL be accepted on the next rising edge.

Configuration
REQ-027 Macro CUBIC_SKIP_SUB_EN:
- Defined: CALC SHALL compare r against b itself; when r < b, REQ is skipped entirely (no addsub_req, y unchanged) and flow proceeds directly to the next CALC or to completion. With ready at 1, latency for x=0 is 3 cycles.
- Undefined: every iteration issues a request as in REQ-015/016.

Verification
REQ-028 Ready tied to 1, macro undefined:
- x=0 → y=0; x=7 → 1; x=8 → 2;
- x=26 → 2; x=27 → 3;
- x=215 → 5; x=216 → 6; x=255 → 6;
- busy_o high exactly 6 cycles each.
REQ-029 x=125 with addsub_ready delayed 3 cycles in every REQ → y=5, busy_o 15 cycles, operands stable during each wait.
REQ-030 start_i pulsed with x=1 while busy from x=64 → y=4, no second run begins, y_bo never shows 1.
REQ-031 rst_i asserted in the third busy cycle of x=200 → busy_o=0, y_bo=0 immediately; new run x=64 afterwards → 4.
REQ-032 Macro defined, x=0 → y=0, zero requests, busy 3 cycles; x=255 → 6 with requests only when r>=b.
REQ-033 Arbiter check: requests at indices 0 and 1 together → ec4_2 outputs 1, dc2_4 outputs 0010, cubic granted.

Source files
------------

// File: rtl/cubic.sv
// cubic: sequential 8-bit integer cube root driving a shared adder/subtractor, plus the ec4_2/dc2_4 arbiter parts.
// Optional CUBIC_SKIP_SUB_EN compares locally and skips requests whose subtraction would not be taken.
module cubic (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] x_bi,
    input  logic       start_i,
    output logic       busy_o,
    output logic [2:0] y_bo,
    output logic       addsub_req,
    input  logic       addsub_ready,
    output logic       addsub_mode,
    output logic [7:0] addsub_a,
    output logic [7:0] addsub_b,
    input  logic [7:0] addsub_res
);
    typedef enum logic [1:0] {IDLE, CALC, REQ} st_t;
    st_t        st_q;
    logic [7:0] r_q, b_q, yw, b_d;
    logic [2:0] y_q, yo_q, s_q, y2, y_inc;
    logic       ge;
    // y never exceeds 3 before doubling, so the doubled value fits in 3 bits
    assign y2    = {y_q[1:0], 1'b0};
    assign yw    = {5'd0, y2};
    assign b_d   = (yw * 8'd3 * (yw + 8'd1) + 8'd1) << s_q;
    assign ge    = r_q >= b_q;
    assign y_inc = y_q + {2'b00, ge};
    assign busy_o      = st_q != IDLE;
    assign y_bo        = yo_q;
    assign addsub_req  = st_q == REQ;
    assign addsub_mode = !addsub_req;
    assign addsub_a    = addsub_req ? r_q : 8'd0;
    assign addsub_b    = addsub_req ? b_q : 8'd0;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            st_q <= IDLE;
            r_q  <= 8'd0;
            b_q  <= 8'd0;
            y_q  <= 3'd0;
            yo_q <= 3'd0;
            s_q  <= 3'd0;
        end else begin
            case (st_q)
                IDLE: if (start_i) begin
                    r_q  <= x_bi;
                    y_q  <= 3'd0;
                    s_q  <= 3'd6;
                    st_q <= CALC;
                end
                CALC: begin
                    b_q <= b_d;
                    y_q <= y2;
`ifdef CUBIC_SKIP_SUB_EN
                    if (r_q >= b_d) st_q <= REQ;
                    else if (s_q == 3'd0) begin
                        yo_q <= y2;
                        st_q <= IDLE;
                    end else s_q <= s_q - 3'd3;
`else
                    st_q <= REQ;
`endif
                end
                REQ: if (addsub_ready) begin
                    if (ge) r_q <= addsub_res;
                    y_q <= y_inc;
                    if (s_q == 3'd0) begin
                        yo_q <= y_inc;
                        st_q <= IDLE;
                    end else begin
                        s_q  <= s_q - 3'd3;
                        st_q <= CALC;
                    end
                end
                default: st_q <= IDLE;
            endcase
        end
    end
endmodule

// ec4_2: 4-to-2 priority encoder, highest asserted index wins, all-zero encodes 0.
module ec4_2 (
    input  logic [3:0] req_i,
    output logic [1:0] idx_o
);
    assign idx_o = req_i[3] ? 2'd3 : req_i[2] ? 2'd2 : req_i[1] ? 2'd1 : 2'd0;
endmodule

// dc2_4: 2-to-4 one-hot decoder.
module dc2_4 (
    input  logic [1:0] idx_i,
    output logic [3:0] dec_o
);
    assign dec_o = 4'b0001 << idx_i;
endmodule

// File: tb/tb_cubic.sv
// tb_cubic: randomized scoreboard bench for cubic against an arithmetic cube-root model, plus arbiter part checks.
module tb_cubic;
    logic       clk = 0, rst_n = 0, start = 0, ready = 0;
    logic [7:0] x = 0, a, b, res;
    logic       busy, req, mode;
    logic [2:0] y;
    logic [3:0] areq, agnt;
    logic [1:0] aidx;
    typedef struct {logic [2:0] y; int lat; int nreq;} exp_t;
    exp_t       q[$];
    int         checks = 0, errors = 0, dly = 0, wcnt = 0, bcnt = 0, nreq = 0;
    logic       bprev = 0;
    logic [2:0] yprev = 0;
    logic [7:0] a0 = 0, b0 = 0;

    always #5 clk = ~clk;
    assign res = mode ? a + b : a - b;

    cubic dut (.clk_i(clk), .rst_i(rst_n), .x_bi(x), .start_i(start), .busy_o(busy), .y_bo(y),
               .addsub_req(req), .addsub_ready(ready), .addsub_mode(mode), .addsub_a(a),
               .addsub_b(b), .addsub_res(res));
    ec4_2 u_enc (.req_i(areq), .idx_o(aidx));
    dc2_4 u_dec (.idx_i(aidx), .dec_o(agnt));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", n, act, want);
        end
    endtask

    function automatic int cbrt(input int v);
        int k = 0;
        while ((k + 1) * (k + 1) * (k + 1) <= v) k++;
        return k;
    endfunction

    // each set result bit corresponds to exactly one taken subtraction
    function automatic exp_t model(input int v, input int d);
        exp_t e;
        int   p;
        e.y = 3'(cbrt(v));
        p = int'(e.y[0]) + int'(e.y[1]) + int'(e.y[2]);
`ifdef CUBIC_SKIP_SUB_EN
        e.lat = 3 + p * (1 + d);
        e.nreq = p;
`else
        e.lat = 6 + 3 * d;
        e.nreq = 3;
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            bprev = 0; bcnt = 0; nreq = 0; wcnt = 0; ready = 0; yprev = y;
        end else begin
            if (bprev && !busy) begin
                if (q.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("y", y, e.y);
                    chk("busy_cycles", bcnt, e.lat);
                    chk("requests", nreq, e.nreq);
                end
                bcnt = 0; nreq = 0;
            end else if (y !== yprev) chk("y_hold", y, yprev);
            if (busy) bcnt++;
            if (req) begin
                chk("req_mode", mode, 0);
                if (wcnt == 0) begin a0 = a; b0 = b; end
                else begin chk("a_stable", a, a0); chk("b_stable", b, b0); end
                ready = wcnt >= dly;
                if (ready) begin wcnt = 0; nreq++; end else wcnt++;
            end else begin
                if (a !== 8'd0 || b !== 8'd0 || mode !== 1'b1) chk("idle_bus", {mode, a, b}, 17'h10000);
                ready = 1'($urandom_range(0, 1));
                wcnt = 0;
            end
            bprev = busy; yprev = y;
        end
    end

    task automatic run(input logic [7:0] xv, input int d);
        int t = 0;
        @(negedge clk);
        dly = d; x = xv; start = 1;
        q.push_back(model(xv, d));
        @(negedge clk);
        start = 0; x = 8'($urandom);
        while (busy && t < 200) begin @(negedge clk); t++; end
        if (busy) chk("timeout", busy, 0);
    endtask

    initial begin
        exp_t e;
        logic [7:0] dir [8] = '{8'd0, 8'd7, 8'd8, 8'd26, 8'd27, 8'd215, 8'd216, 8'd255};
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_y", y, 0);
        chk("rst_req", req, 0);
        @(negedge clk) rst_n = 1;
        foreach (dir[i]) run(dir[i], 0);
        run(8'd125, 3);
        for (int i = 0; i < 24; i++) run(8'($urandom), $urandom_range(0, 2));
        // start pulses mid-run and on the completing edge must be ignored
        @(negedge clk);
        dly = 0; x = 8'd64; start = 1;
        e = model(64, 0);
        q.push_back(e);
        @(negedge clk) start = 0;
        @(negedge clk) begin x = 8'd1; start = 1; end
        @(negedge clk) start = 0;
        repeat (e.lat - 3) @(negedge clk);
        x = 8'd1; start = 1;
        @(negedge clk) start = 0;
        repeat (3) begin @(negedge clk); chk("no_restart", busy, 0); end
        // reset during the third busy cycle of x=200
        @(negedge clk) begin x = 8'd200; start = 1; end
        @(negedge clk) start = 0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_y", y, 0);
        chk("abort_req", req, 0);
        @(negedge clk);
        @(negedge clk) rst_n = 1;
        run(8'd64, 0);
        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        for (int p = 0; p < 16; p++) begin
            int w = 0;
            areq = 4'(p);
            for (int i = 0; i < 4; i++) if (areq[i]) w = i;
            #1;
            chk("enc_idx", aidx, w);
            chk("dec_onehot", agnt, 1 << w);
        end
        areq = 4'b0011;
        #1;
        chk("cubic_granted", agnt[1], 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
